// File: rtl/acc_frame_serializer.sv
// -----------------------------------------------------------------------------
// acc_frame_serializer
//
// Output serializer that sits directly after the I/Q accumulator stage.
// A parallel frame of NUM_WORDS accumulated words (SA I, SA Q, CML I, CML Q)
// is accepted into a single-entry buffer. It is then shifted out MSB-first
// and followed by one even-parity bit. A one-cycle serialStart marker
// flags the first payload bit of each frame.
//
// Handshake (valid/ready):
//   A frame transfers on a rising edge where frame_valid && frame_ready.
//   frame_ready is simply !buf_full, so it has no combinational path from
//   frame_valid. Upstream may hold frame_valid while frame_ready is low, but
//   every such edge drops the offered data and sets the sticky overrun flag.
//
// Ports:
//   clk            shift clock; all logic on the rising edge
//   reset_n        asynchronous active-low reset
//   frame_valid    upstream presents a frame on frame_data
//   frame_data     packed frame; word 0 (SA I) in the top ACC_WIDTH bits
//   frame_ready    buffer empty
//   overrun_clear  synchronous clear of overrun (a same-cycle set wins)
//   serialStart    high during the first payload bit of each frame
//   serialOut      serial data; 0 when idle
//   busy           shifter active (SHIFT or PARITY)
//   overrun        sticky: a frame was offered while the buffer was full
//   frame_count    frames fully transmitted, parity included; wraps at 256
//   state_dbg      FSM state for debug: 0 = IDLE, 1 = SHIFT, 2 = PARITY
// -----------------------------------------------------------------------------
module acc_frame_serializer #(
  parameter int ACC_WIDTH = 16,
  parameter int NUM_WORDS = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           frame_valid,
  input  logic [ACC_WIDTH*NUM_WORDS-1:0] frame_data,
  output logic                           frame_ready,
  input  logic                           overrun_clear,
  output logic                           serialStart,
  output logic                           serialOut,
  output logic                           busy,
  output logic                           overrun,
  output logic [7:0]                     frame_count,
  output logic [1:0]                     state_dbg
);

  localparam int FW = ACC_WIDTH * NUM_WORDS;
  localparam int CW = $clog2(FW);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t          state;
  logic            buf_full;
  logic [FW-1:0]   buf_data;
  logic [FW-1:0]   shreg;
  logic [CW-1:0]   bit_cnt;
  logic            par_acc;
  logic            do_load;
  logic            last_bit;

  assign frame_ready = !buf_full;
  assign state_dbg   = state;

  // The shifter takes the buffer from IDLE, or straight out of PARITY, so
  // back-to-back frames have no idle gap between them.
  assign do_load  = buf_full && ((state == IDLE) || (state == PARITY));
  assign last_bit = (bit_cnt == CW'(FW - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      buf_full    <= 1'b0;
      buf_data    <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      par_acc     <= 1'b0;
      serialStart <= 1'b0;
      serialOut   <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      // Buffer side. An accept needs buf_full == 0 and a load needs
      // buf_full == 1, so the two writes of buf_full below never collide.
      if (frame_valid && !buf_full) begin
        buf_data <= frame_data;
        buf_full <= 1'b1;
      end

      if (frame_valid && buf_full) begin
        overrun <= 1'b1;
      end else if (overrun_clear) begin
        overrun <= 1'b0;
      end

      // Leaving PARITY always completes a frame, whether the FSM goes to
      // IDLE or loads the next frame.
      if (state == PARITY) begin
        frame_count <= frame_count + 8'd1;
      end

      if (do_load) begin
        state       <= SHIFT;
        shreg       <= buf_data;
        buf_full    <= 1'b0;
        bit_cnt     <= '0;
        serialOut   <= buf_data[FW-1];
        par_acc     <= buf_data[FW-1];
        serialStart <= 1'b1;
        busy        <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            serialOut   <= 1'b0;
            serialStart <= 1'b0;
            busy        <= 1'b0;
          end
          SHIFT: begin
            serialStart <= 1'b0;
            if (last_bit) begin
              // par_acc already covers all FW payload bits.
              state     <= PARITY;
              serialOut <= par_acc;
            end else begin
              // shreg[FW-1] is the bit on the wire; the next one is below it.
              shreg     <= {shreg[FW-2:0], 1'b0};
              serialOut <= shreg[FW-2];
              par_acc   <= par_acc ^ shreg[FW-2];
              bit_cnt   <= bit_cnt + CW'(1);
            end
          end
          PARITY: begin
            state       <= IDLE;
            serialOut   <= 1'b0;
            serialStart <= 1'b0;
            busy        <= 1'b0;
          end
          default: begin
            state       <= IDLE;
            serialOut   <= 1'b0;
            serialStart <= 1'b0;
            busy        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
